// File: rtl/nfifo2mem_rel.sv
// Multi-flow write FIFOs sharing one word memory, with head-relative random-access
// reads, explicit per-flow release, flush and a stallable 1/2-stage read pipeline.
module nfifo2mem_rel #(
  parameter int DATA_WIDTH = 64,
  parameter int FLOWS      = 4,
  parameter int BLOCK_SIZE = 8,
  parameter int AF_LVL     = 6,
  parameter int OUTPUT_REG = 0
) (
  input  logic                                      CLK,
  input  logic                                      RESET_N,
  input  logic [DATA_WIDTH-1:0]                     DATA_IN,
  input  logic [FLOWS-1:0]                          WRITE,
  output logic [FLOWS-1:0]                          FULL,
  output logic [FLOWS-1:0]                          ALMOST_FULL,
  input  logic [FLOWS-1:0]                          FLUSH,
  input  logic [$clog2(FLOWS)-1:0]                  BLOCK_ADDR,
  input  logic [$clog2(BLOCK_SIZE)-1:0]             RD_ADDR,
  input  logic                                      READ,
  input  logic                                      PIPE_EN,
  output logic [DATA_WIDTH/FLOWS-1:0]               DATA_OUT,
  output logic                                      DATA_VLD,
  input  logic [FLOWS*($clog2(BLOCK_SIZE)+1)-1:0]   REL_LEN,
  input  logic [FLOWS-1:0]                          REL_LEN_DV,
  output logic [FLOWS-1:0]                          REL_ERR,
  output logic [FLOWS-1:0]                          EMPTY,
  output logic [FLOWS*($clog2(BLOCK_SIZE)+1)-1:0]   STATUS
);

  localparam int FW = DATA_WIDTH / FLOWS;
  localparam int AW = $clog2(BLOCK_SIZE);
  localparam int CW = AW + 1;

  logic [FLOWS*FW-1:0] flow_word;
  logic [FLOWS-1:0]    flow_rd_ok;

  for (genvar g = 0; g < FLOWS; g++) begin : g_flow
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          err;
    logic [FW-1:0] mem [BLOCK_SIZE];
    logic [CW-1:0] rel_field;
    logic [CW-1:0] rel;
    logic          over;
    logic          wr_acc;
    logic [AW-1:0] rd_idx;

    assign rel_field = REL_LEN[g*CW +: CW];
    assign wr_acc    = WRITE[g] & ~FULL[g];
    assign over      = REL_LEN_DV[g] && (rel_field > cnt);
    // Release is clamped to what the flow actually holds; the excess only raises the error flag.
    assign rel       = !REL_LEN_DV[g] ? '0 : (over ? cnt : rel_field);

    assign FULL[g]              = (cnt == CW'(BLOCK_SIZE));
    assign ALMOST_FULL[g]       = (cnt >= CW'(AF_LVL));
    assign EMPTY[g]             = (cnt == '0);
    assign STATUS[g*CW +: CW]   = cnt;
    assign REL_ERR[g]           = err;

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        err    <= 1'b0;
      end else if (FLUSH[g]) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        err    <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
        rd_ptr <= rd_ptr + rel[AW-1:0];
        cnt    <= cnt + CW'(wr_acc) - rel;
        if (over) err <= 1'b1;
      end
    end

    // Flush does not gate the memory write: the pointer reset makes the word unreachable anyway.
    always_ff @(posedge CLK) begin
      if (wr_acc) mem[wr_ptr] <= DATA_IN[g*FW +: FW];
    end

    assign rd_idx                 = rd_ptr + RD_ADDR;
    assign flow_word[g*FW +: FW]  = mem[rd_idx];
    assign flow_rd_ok[g]          = ({1'b0, RD_ADDR} < cnt);
  end

  logic [FW-1:0] sel_word;
  logic          sel_ok;
  logic [FW-1:0] s1_data;
  logic          s1_vld;

  assign sel_word = flow_word[BLOCK_ADDR*FW +: FW];
  assign sel_ok   = flow_rd_ok[BLOCK_ADDR];

  // Memory is sampled before this edge's writes land, giving read-before-write behaviour.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else if (PIPE_EN) begin
      s1_vld <= READ & sel_ok;
      if (READ) s1_data <= sel_word;
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic [FW-1:0] s2_data;
    logic          s2_vld;

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        s2_vld  <= 1'b0;
        s2_data <= '0;
      end else if (PIPE_EN) begin
        s2_vld  <= s1_vld;
        s2_data <= s1_data;
      end
    end

    assign DATA_OUT = s2_data;
    assign DATA_VLD = s2_vld;
  end else begin : g_noreg
    assign DATA_OUT = s1_data;
    assign DATA_VLD = s1_vld;
  end

endmodule

// File: tb/tb_nfifo2mem_rel.sv
// Directed bench for nfifo2mem_rel: one instance per read latency, driven by the same stimulus.
module tb_nfifo2mem_rel;

  logic        CLK;
  logic        RESET_N;
  logic [63:0] DATA_IN;
  logic [3:0]  WRITE;
  logic [3:0]  FLUSH;
  logic [1:0]  BLOCK_ADDR;
  logic [2:0]  RD_ADDR;
  logic        READ;
  logic        PIPE_EN;
  logic [15:0] REL_LEN;
  logic [3:0]  REL_LEN_DV;

  logic [3:0]  FULL, ALMOST_FULL, REL_ERR, EMPTY;
  logic [15:0] DATA_OUT, STATUS;
  logic        DATA_VLD;

  logic [3:0]  d2_full, d2_almost_full, d2_rel_err, d2_empty;
  logic [15:0] d2_data_out, d2_status;
  logic        d2_data_vld;

  int checks = 0;
  int errors = 0;

  nfifo2mem_rel #(.OUTPUT_REG(0)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .WRITE(WRITE),
    .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .FLUSH(FLUSH),
    .BLOCK_ADDR(BLOCK_ADDR), .RD_ADDR(RD_ADDR), .READ(READ), .PIPE_EN(PIPE_EN),
    .DATA_OUT(DATA_OUT), .DATA_VLD(DATA_VLD), .REL_LEN(REL_LEN),
    .REL_LEN_DV(REL_LEN_DV), .REL_ERR(REL_ERR), .EMPTY(EMPTY), .STATUS(STATUS)
  );

  nfifo2mem_rel #(.OUTPUT_REG(1)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .WRITE(WRITE),
    .FULL(d2_full), .ALMOST_FULL(d2_almost_full), .FLUSH(FLUSH),
    .BLOCK_ADDR(BLOCK_ADDR), .RD_ADDR(RD_ADDR), .READ(READ), .PIPE_EN(PIPE_EN),
    .DATA_OUT(d2_data_out), .DATA_VLD(d2_data_vld), .REL_LEN(REL_LEN),
    .REL_LEN_DV(REL_LEN_DV), .REL_ERR(d2_rel_err), .EMPTY(d2_empty), .STATUS(d2_status)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus;
    DATA_IN    = '0;
    WRITE      = '0;
    FLUSH      = '0;
    BLOCK_ADDR = '0;
    RD_ADDR    = '0;
    READ       = 1'b0;
    PIPE_EN    = 1'b1;
    REL_LEN    = '0;
    REL_LEN_DV = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int f, input logic [15:0] d);
    WRITE[f]            = 1'b1;
    DATA_IN[f*16 +: 16] = d;
    tick();
    WRITE[f] = 1'b0;
  endtask

  task automatic read_one(input logic [1:0] blk, input logic [2:0] off);
    READ       = 1'b1;
    BLOCK_ADDR = blk;
    RD_ADDR    = off;
    tick();
    READ = 1'b0;
  endtask

  initial begin
    applyStimulus();
    RESET_N = 1'b0;
    tick();
    tick();
    checkOutput("reset_empty",    EMPTY, 4'hF);
    checkOutput("reset_status",   STATUS, 16'h0);
    checkOutput("reset_full",     {ALMOST_FULL, FULL}, 8'h0);
    checkOutput("reset_vld",      DATA_VLD, 1'b0);
    checkOutput("reset_dout",     DATA_OUT, 16'h0);
    checkOutput("reset_relerr",   REL_ERR, 4'h0);
    RESET_N = 1'b1;
    tick();

    $display("[TB] fill flow 2");
    for (int k = 0; k < 8; k++) begin
      write_word(2, 16'(16'hA0 + k));
      checkOutput($sformatf("fill_af_%0d", k + 1), ALMOST_FULL[2], (k >= 5));
    end
    checkOutput("fill_full",   FULL, 4'b0100);
    checkOutput("fill_status", STATUS[11:8], 4'd8);
    write_word(2, 16'h00FF);
    checkOutput("fill_drop_status", STATUS[11:8], 4'd8);
    checkOutput("fill_other_empty", EMPTY, 4'b1011);
    read_one(2'd2, 3'd0);
    checkOutput("fill_rd0", {DATA_VLD, DATA_OUT}, {1'b1, 16'hA0});
    read_one(2'd2, 3'd7);
    checkOutput("fill_rd7", {DATA_VLD, DATA_OUT}, {1'b1, 16'hA7});

    $display("[TB] random-access read on flow 1");
    for (int k = 0; k < 5; k++) write_word(1, 16'(16'h10 + k));
    READ = 1'b1; BLOCK_ADDR = 2'd1; RD_ADDR = 3'd3;
    tick();
    checkOutput("ra_l1_first", {DATA_VLD, DATA_OUT}, {1'b1, 16'h13});
    checkOutput("ra_l2_wait",  d2_data_vld, 1'b0);
    RD_ADDR = 3'd0;
    tick();
    READ = 1'b0;
    checkOutput("ra_l1_second", {DATA_VLD, DATA_OUT}, {1'b1, 16'h10});
    checkOutput("ra_l2_first",  {d2_data_vld, d2_data_out}, {1'b1, 16'h13});
    tick();
    checkOutput("ra_l1_idle",   DATA_VLD, 1'b0);
    checkOutput("ra_l2_second", {d2_data_vld, d2_data_out}, {1'b1, 16'h10});
    REL_LEN[7:4] = 4'd0; REL_LEN_DV[1] = 1'b1;
    tick();
    REL_LEN_DV = '0;
    checkOutput("rel_zero_noop", {REL_ERR[1], STATUS[7:4]}, {1'b0, 4'd5});

    $display("[TB] release with wrap on flow 0");
    for (int k = 0; k < 8; k++) write_word(0, 16'(16'hC0 + k));
    REL_LEN[3:0] = 4'd5; REL_LEN_DV[0] = 1'b1;
    tick();
    REL_LEN_DV = '0;
    checkOutput("wrap_rel_cnt", STATUS[3:0], 4'd3);
    checkOutput("wrap_rel_af",  ALMOST_FULL[0], 1'b0);
    write_word(0, 16'hB0);
    write_word(0, 16'hB1);
    checkOutput("wrap_af_cnt5", ALMOST_FULL[0], 1'b0);
    write_word(0, 16'hB2);
    checkOutput("wrap_af_cnt6", {ALMOST_FULL[0], STATUS[3:0]}, {1'b1, 4'd6});
    read_one(2'd0, 3'd5);
    checkOutput("wrap_rd5", {DATA_VLD, DATA_OUT}, {1'b1, 16'hB2});
    read_one(2'd0, 3'd0);
    checkOutput("wrap_rd0", {DATA_VLD, DATA_OUT}, {1'b1, 16'hC5});

    $display("[TB] over-release and flush on flow 3");
    write_word(3, 16'h30);
    write_word(3, 16'h31);
    REL_LEN[15:12] = 4'd4; REL_LEN_DV[3] = 1'b1;
    write_word(3, 16'h32);
    REL_LEN_DV = '0;
    checkOutput("over_cnt", STATUS[15:12], 4'd1);
    checkOutput("over_err", REL_ERR, 4'b1000);
    tick();
    checkOutput("over_err_sticky", REL_ERR, 4'b1000);
    FLUSH[3] = 1'b1;
    write_word(3, 16'h33);
    FLUSH = '0;
    checkOutput("flush_state", {REL_ERR[3], EMPTY[3], STATUS[15:12]}, {1'b0, 1'b1, 4'd0});
    checkOutput("flush_others", STATUS[11:0], {4'd8, 4'd5, 4'd6});

    $display("[TB] stall and invalid read");
    write_word(3, 16'h40);
    write_word(3, 16'h41);
    read_one(2'd1, 3'd2);
    checkOutput("stall_capture", {DATA_VLD, DATA_OUT}, {1'b1, 16'h12});
    PIPE_EN = 1'b0; READ = 1'b1; RD_ADDR = 3'd4;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("stall_hold_%0d", k), {DATA_VLD, DATA_OUT}, {1'b1, 16'h12});
    end
    PIPE_EN = 1'b1; BLOCK_ADDR = 2'd3; RD_ADDR = 3'd4;
    tick();
    checkOutput("invalid_rd", DATA_VLD, 1'b0);
    RD_ADDR = 3'd1;
    tick();
    READ = 1'b0;
    checkOutput("flow3_rd1", {DATA_VLD, DATA_OUT}, {1'b1, 16'h41});
    tick();

    $display("[TB] async reset mid-read");
    read_one(2'd1, 3'd1);
    checkOutput("rst_pre_l1", {DATA_VLD, DATA_OUT}, {1'b1, 16'h11});
    #2 RESET_N = 1'b0;
    #1;
    checkOutput("rst_async_vld", {DATA_VLD, d2_data_vld}, 2'b00);
    checkOutput("rst_async_empty", {EMPTY, d2_empty}, 8'hFF);
    checkOutput("rst_async_status", STATUS, 16'h0);
    tick();
    checkOutput("rst_hold_l2_vld", d2_data_vld, 1'b0);
    RESET_N = 1'b1;
    tick();
    checkOutput("rst_after_l2_vld", d2_data_vld, 1'b0);
    write_word(1, 16'h50);
    write_word(1, 16'h51);
    read_one(2'd1, 3'd1);
    checkOutput("post_rst_l1", {DATA_VLD, DATA_OUT}, {1'b1, 16'h51});
    tick();
    checkOutput("post_rst_l2", {d2_data_vld, d2_data_out}, {1'b1, 16'h51});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nfifo2mem_rel.md
Name: nfifo2mem_rel

Overview:
- Multi-flow buffer: FLOWS independent write FIFOs share one memory of FLOWS*BLOCK_SIZE words, each word DATA_WIDTH/FLOWS bits.
- The read side is random-access within a flow, relative to that flow's head. Space is freed explicitly by per-flow release lengths.
- Successor to the existing nfifo2mem-style buffer. Adds per-flow release lengths, overrun error flags, almost-full thresholds, per-flow flush and a stallable 1- or 2-stage read pipeline.
- Sits between the per-flow producers and a DMA/memory reader.

Parameters:
- DATA_WIDTH, 64: total write width; per-flow word width FW = DATA_WIDTH/FLOWS, must divide exactly.
- FLOWS, 4: number of flows, >=2, power of 2.
- BLOCK_SIZE, 8: words per flow, power of 2, >=2; AW = log2(BLOCK_SIZE).
- AF_LVL, 6: ALMOST_FULL threshold, range 1..BLOCK_SIZE.
- OUTPUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register stage (2 cycles).

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  reset; one clock, asynchronous, active-low.
- DATA_IN  in  DATA_WIDTH  flow i uses bits [(i+1)*FW-1 : i*FW].
- WRITE  in  FLOWS  per-flow write request.
- FULL  out  FLOWS  flow count equals BLOCK_SIZE.
- ALMOST_FULL  out  FLOWS  flow count >= AF_LVL.
- FLUSH  in  FLOWS  per-flow synchronous clear.
- BLOCK_ADDR  in  log2(FLOWS)  flow selected for a read.
- RD_ADDR  in  AW  word offset from the flow head.
- READ  in  1  read request.
- PIPE_EN  in  1  read-pipeline advance enable.
- DATA_OUT  out  FW  read data.
- DATA_VLD  out  1  DATA_OUT valid.
- REL_LEN  in  FLOWS*(AW+1)  per-flow release length; field i is bits [(i+1)*(AW+1)-1 : i*(AW+1)].
- REL_LEN_DV  in  FLOWS  per-flow release strobe.
- REL_ERR  out  FLOWS  sticky over-release flag.
- EMPTY  out  FLOWS  flow count is 0.
- STATUS  out  FLOWS*(AW+1)  per-flow occupancy count, same packing as REL_LEN.

Behaviour:

Reset (RESET_N low, asynchronous)
- All pointers and counts are 0.
- FULL=0, ALMOST_FULL=0, EMPTY=all 1, STATUS=0, REL_ERR=0, DATA_VLD=0, DATA_OUT=0.
- Memory contents are not reset.
- A read in flight during reset is discarded; it produces no DATA_VLD.

Per-flow state
- wr_ptr, rd_ptr: AW bits each, wrap modulo BLOCK_SIZE.
- cnt: AW+1 bits, range 0..BLOCK_SIZE.
- FULL, ALMOST_FULL, EMPTY and STATUS are decoded combinationally from the registered cnt only.

Write
- Accepted when WRITE[i]=1 and FULL[i]=0.
- Stores the flow's DATA_IN slice at mem[i*BLOCK_SIZE + wr_ptr]; then wr_ptr+1.
- WRITE while FULL is ignored silently; no state change.

Release
- On REL_LEN_DV[i], rel = min(REL_LEN field i, cnt).
- rd_ptr advances by rel (mod BLOCK_SIZE).
- If the REL_LEN field exceeds cnt, REL_ERR[i] is set.
- REL_LEN = 0 is a no-op.

Count update
- Same cycle: cnt_next = cnt + write_accepted - rel.
- A write and a release in the same cycle are both applied.
- FULL is based on the registered cnt, so a release while full does not allow a same-cycle write.

Flush
- FLUSH[i] clears wr_ptr, rd_ptr, cnt and REL_ERR of flow i.
- It takes priority over a same-cycle write or release on that flow.
- Other flows are unaffected.
- Reads already in the pipeline complete with the old data.

Read pipeline
- Request captured when READ=1 and PIPE_EN=1.
- Address = BLOCK_ADDR*BLOCK_SIZE + ((rd_ptr[BLOCK_ADDR] + RD_ADDR) mod BLOCK_SIZE), using the pre-update rd_ptr of the capture cycle.
- Valid only if RD_ADDR < cnt[BLOCK_ADDR] at capture. Otherwise the request is consumed but yields DATA_VLD=0 in its output slot.
- Latency: result appears 1 cycle after capture (OUTPUT_REG=0) or 2 cycles (OUTPUT_REG=1). Fully pipelined; one request per cycle.
- PIPE_EN=0 freezes all pipeline stages. DATA_OUT and DATA_VLD hold their values; READ is ignored.
- Memory is read-before-write. A read captured in the same cycle as a write to the same word returns the old word. This collision cannot occur for valid offsets; only invalid reads can hit it.

Test Plan:
1. Fill: write 8 words 0xA0..0xA7 to flow 2, then 1 more → FULL[2]=1, STATUS field 2=8, ALMOST_FULL[2]=1 from the 6th write onward, 9th write dropped, other flows EMPTY=1.
2. Random-access read: flow 1 holds 0x10..0x14; read BLOCK_ADDR=1 with RD_ADDR=3, then RD_ADDR=0 → with OUTPUT_REG=0, DATA_VLD=1 one cycle after each capture with 0x13 then 0x10; with OUTPUT_REG=1, the same two results appear two cycles after capture.
3. Release with wrap: flow 0 holds 8 words; release 5, write 3 (0xB0..0xB2), read RD_ADDR=5 → cnt=6, DATA_OUT=0xB2; ALMOST_FULL[0] drops to 0 after the release and returns to 1 on the third write.
4. Over-release and simultaneous events: flow 3 cnt=2; REL_LEN=4 together with an accepted write → cnt=1, REL_ERR[3]=1 and it stays 1; FLUSH[3] → cnt=0, REL_ERR[3]=0, EMPTY[3]=1.
5. Stall and invalid read: capture a valid read, hold PIPE_EN=0 for 3 cycles → DATA_OUT/DATA_VLD frozen, READ pulses ignored; then read RD_ADDR=4 on a flow with cnt=2 → DATA_VLD=0 in that slot.
6. Async reset mid-read: assert RESET_N=0 between a read capture and its output cycle → DATA_VLD=0 immediately, all EMPTY=1, STATUS=0; a read after reset release behaves as in scenario 2.
